vpp_rd_arb: RTL and testbench
=============================

Name: vpp_rd_arb

Overview:
- Round-robin arbiter that shares the single VPP memory read port between the Y, U and V fetch engines that fill the scaler line FIFOs.
- Latches one read burst command per grant, drives it on an OCP-style master command interface, and tracks outstanding bursts in an ordering FIFO.
- Steers returning read beats to the requester that issued the burst.
- Sits between the HS/VS fetch FSMs and the LRBIU.

Parameters:
AW, 32, address width
BLW, 4, burst-length field width; legal lengths are 1..2^BLW-1 beats
OUTSTD, 4, maximum outstanding bursts; depth of the ordering FIFO, power of 2

Ports:
vpp_clk  input  1  clock
vpp_rst_b  input  1  asynchronous active-low reset
i_req  input  3  per-requester read request; bit0=Y, bit1=U, bit2=V
i_addr  input  3*AW  request addresses; slice k belongs to requester k
i_blen  input  3*BLW  burst lengths in beats; slice k belongs to requester k
o_gnt  output  3  one-cycle pulse when the requester's command is accepted by the slave
o_mcmd  output  3  OCP command: 3'b000 IDLE, 3'b010 RD
o_maddr  output  AW  command address
o_mburstlength  output  BLW  command burst length
i_scmdaccept  input  1  slave accepts command
i_sresp  input  2  2'b00 NULL, 2'b01 DVA, 2'b11 ERR
i_sdata  input  32  read data
o_rvalid  output  3  one-hot read-data valid, registered
o_rdata  output  32  read data, registered
o_busy  output  1  command pending or outstanding count nonzero
o_err  output  1  sticky error flag
i_err_clr  input  1  synchronous clear for o_err

Behaviour:
- Reset values: o_gnt=0, o_mcmd=IDLE, o_maddr=0, o_mburstlength=0, o_rvalid=0, o_rdata=0, o_busy=0, o_err=0.
- Reset also clears internal state: FSM=IDLE, RR pointer last=V (Y has first priority), outstanding count=0, FIFO empty.
- FSM states: IDLE and CMD.
- IDLE -> CMD:
  - Transition when any i_req bit is set and the outstanding count < OUTSTD.
  - Winner: first set bit after `last`, scanning Y->U->V cyclically.
  - Latch id, the winner's i_addr slice and its i_blen slice. A blen of 0 is latched as 1.
  - o_mcmd=RD is driven from the next cycle.
- CMD:
  - o_mcmd, o_maddr and o_mburstlength are held stable until i_scmdaccept=1.
  - In the accept cycle: o_gnt[id]=1 (combinational with accept), push {id, blen} into the FIFO, outstanding count +1, last=id, go to IDLE.
  - o_mcmd returns to IDLE in the following cycle.
  - Back-to-back commands are spaced a minimum of 2 cycles apart.
- Requester contract: hold req, addr and blen until gnt. A request dropped after latching still completes; the latched command is authoritative.
- Response path:
  - On i_sresp=DVA or ERR with the FIFO non-empty: next cycle o_rvalid[head.id]=1 and o_rdata=i_sdata.
  - The beat counter starts at head.blen and decrements per beat.
  - On the last beat: pop the FIFO and decrement the outstanding count.
- ERR beats are delivered as data and set o_err.
- Beat with the FIFO empty: data dropped, o_rvalid stays 0, o_err set.
- Simultaneous accept and last beat: count unchanged; FIFO push and pop both occur.
- Full condition: arbitration uses the registered count. At count==OUTSTD no new grant is made, even if a pop occurs in the same cycle.
- o_err is cleared by i_err_clr. A set event in the same cycle as the clear wins.
- Reset mid-burst: all state is dropped. Late beats after reset are treated as unexpected and set o_err.

Test Plan:
- Single request: i_req=001, addr=0x2000_0100, blen=4, accept on 2nd CMD cycle -> o_mcmd=RD for 2 cycles, o_gnt=001 on the accept cycle; 4 DVA beats -> o_rvalid=001 ×4 with data matched 1 cycle late; o_busy falls after the last beat.
- Round-robin: i_req=111 held, immediate accept -> grant order Y,U,V,Y,U,V; after granting U with i_req=101, the next grant is V.
- Outstanding limit: OUTSTD=4, no responses, continuous requests -> exactly 4 accepts, then o_mcmd stays IDLE; one 1-beat burst completes -> 5th command issues.
- Interleaved ordering: grants Y(blen 2), V(blen 3) -> beats 1-2 route to Y and beats 3-5 route to V; simultaneous accept+last-beat keeps the count correct.
- Errors: DVA with no outstanding -> o_err=1, no o_rvalid; ERR beat mid-burst -> delivered, o_err=1; i_err_clr -> o_err=0.
- Async reset asserted in CMD with 2 bursts outstanding -> all outputs go to reset values immediately; the next request is granted to Y.

Source files
------------

// File: rtl/vpp_rd_arb.sv
// Round-robin arbiter sharing the VPP memory read port between the Y, U and V fetch engines.
// Issues one OCP read burst per grant and steers returning beats back in issue order.
module vpp_rd_arb #(
    parameter int unsigned AW     = 32,
    parameter int unsigned BLW    = 4,
    parameter int unsigned OUTSTD = 4
) (
    input  logic             vpp_clk,
    input  logic             vpp_rst_b,
    input  logic [2:0]       i_req,
    input  logic [3*AW-1:0]  i_addr,
    input  logic [3*BLW-1:0] i_blen,
    output logic [2:0]       o_gnt,
    output logic [2:0]       o_mcmd,
    output logic [AW-1:0]    o_maddr,
    output logic [BLW-1:0]   o_mburstlength,
    input  logic             i_scmdaccept,
    input  logic [1:0]       i_sresp,
    input  logic [31:0]      i_sdata,
    output logic [2:0]       o_rvalid,
    output logic [31:0]      o_rdata,
    output logic             o_busy,
    output logic             o_err,
    input  logic             i_err_clr
);

    localparam int unsigned PW = (OUTSTD > 1) ? $clog2(OUTSTD) : 1;
    localparam int unsigned CW = $clog2(OUTSTD + 1);
    localparam logic [2:0] MCMD_IDLE = 3'b000;
    localparam logic [2:0] MCMD_RD   = 3'b010;

    typedef enum logic [0:0] {StIdle, StCmd} state_e;

    state_e           state_q;
    logic [1:0]       last_q;
    logic [1:0]       id_q;
    logic [CW-1:0]    cnt_q;
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [BLW-1:0]   beat_q;
    logic             mid_q;
    logic [1:0]       fifo_id_q   [2**PW];
    logic [BLW-1:0]   fifo_blen_q [2**PW];

    logic [1:0]       cand;
    logic             win_found;
    logic [1:0]       win_id;
    logic [AW-1:0]    win_addr;
    logic [BLW-1:0]   win_blen_raw;
    logic [BLW-1:0]   win_blen;
    logic             accept;
    logic             beat;
    logic             fifo_ne;
    logic [1:0]       head_id;
    logic [BLW-1:0]   head_blen;
    logic [BLW-1:0]   beat_rem;
    logic             pop;
    logic             err_set;

    // Scan cyclically starting with the requester after the last one served.
    always_comb begin
        cand      = (last_q == 2'd2) ? 2'd0 : last_q + 2'd1;
        win_found = 1'b0;
        win_id    = 2'd0;
        for (int k = 0; k < 3; k++) begin
            if (!win_found && i_req[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
            cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
        end
    end

    assign win_addr     = i_addr[int'(win_id)*AW +: AW];
    assign win_blen_raw = i_blen[int'(win_id)*BLW +: BLW];
    assign win_blen     = (win_blen_raw == '0) ? BLW'(1) : win_blen_raw;

    assign accept    = (state_q == StCmd) && i_scmdaccept;
    assign beat      = (i_sresp == 2'b01) || (i_sresp == 2'b11);
    assign fifo_ne   = (cnt_q != '0);
    assign head_id   = fifo_id_q[rd_ptr_q];
    assign head_blen = fifo_blen_q[rd_ptr_q];
    assign beat_rem  = mid_q ? beat_q : head_blen;
    assign pop       = beat && fifo_ne && (beat_rem == BLW'(1));
    assign err_set   = beat && (!fifo_ne || (i_sresp == 2'b11));

    assign o_gnt  = accept ? (3'b001 << id_q) : 3'b000;
    assign o_busy = (state_q == StCmd) || fifo_ne;

    always_ff @(posedge vpp_clk or negedge vpp_rst_b) begin
        if (!vpp_rst_b) begin
            state_q        <= StIdle;
            last_q         <= 2'd2;
            id_q           <= 2'd0;
            o_mcmd         <= MCMD_IDLE;
            o_maddr        <= '0;
            o_mburstlength <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    // Registered count only: a pop this cycle does not free a slot yet.
                    if ((i_req != 3'b000) && (cnt_q < CW'(OUTSTD))) begin
                        state_q        <= StCmd;
                        id_q           <= win_id;
                        o_maddr        <= win_addr;
                        o_mburstlength <= win_blen;
                        o_mcmd         <= MCMD_RD;
                    end
                end
                StCmd: begin
                    if (i_scmdaccept) begin
                        state_q <= StIdle;
                        last_q  <= id_q;
                        o_mcmd  <= MCMD_IDLE;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge vpp_clk or negedge vpp_rst_b) begin
        if (!vpp_rst_b) begin
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            beat_q   <= '0;
            mid_q    <= 1'b0;
            o_rvalid <= 3'b000;
            o_rdata  <= '0;
            o_err    <= 1'b0;
        end else begin
            case ({accept, pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
            if (accept) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)    rd_ptr_q <= rd_ptr_q + PW'(1);
            if (beat && fifo_ne) begin
                if (pop) begin
                    mid_q <= 1'b0;
                end else begin
                    mid_q  <= 1'b1;
                    beat_q <= beat_rem - BLW'(1);
                end
                o_rvalid <= 3'b001 << head_id;
                o_rdata  <= i_sdata;
            end else begin
                o_rvalid <= 3'b000;
            end
            if (err_set) o_err <= 1'b1;
            else if (i_err_clr) o_err <= 1'b0;
        end
    end

    always_ff @(posedge vpp_clk) begin
        if (accept) begin
            fifo_id_q[wr_ptr_q]   <= id_q;
            fifo_blen_q[wr_ptr_q] <= o_mburstlength;
        end
    end

endmodule

// File: tb/tb_vpp_rd_arb.sv
// Scoreboard bench for vpp_rd_arb: a small issue-order model predicts beat routing,
// grants, busy and the sticky error flag.
module tb_vpp_rd_arb;

    localparam int unsigned AW  = 32;
    localparam int unsigned BLW = 4;
    localparam logic [1:0] RNULL = 2'b00;
    localparam logic [1:0] RDVA  = 2'b01;
    localparam logic [1:0] RERR  = 2'b11;

    logic             vpp_clk = 1'b0;
    logic             vpp_rst_b = 1'b1;
    logic [2:0]       i_req = 3'b000;
    logic [3*AW-1:0]  i_addr;
    logic [3*BLW-1:0] i_blen;
    logic [2:0]       o_gnt;
    logic [2:0]       o_mcmd;
    logic [AW-1:0]    o_maddr;
    logic [BLW-1:0]   o_mburstlength;
    logic             i_scmdaccept = 1'b0;
    logic [1:0]       i_sresp = RNULL;
    logic [31:0]      i_sdata = 32'h0;
    logic [2:0]       o_rvalid;
    logic [31:0]      o_rdata;
    logic             o_busy;
    logic             o_err;
    logic             i_err_clr = 1'b0;

    logic [31:0]      addr_tab [3];
    logic [BLW-1:0]   blen_tab [3];

    assign i_addr = {addr_tab[2], addr_tab[1], addr_tab[0]};
    assign i_blen = {blen_tab[2], blen_tab[1], blen_tab[0]};

    vpp_rd_arb #(.AW(AW), .BLW(BLW), .OUTSTD(4)) dut (
        .vpp_clk        (vpp_clk),
        .vpp_rst_b      (vpp_rst_b),
        .i_req          (i_req),
        .i_addr         (i_addr),
        .i_blen         (i_blen),
        .o_gnt          (o_gnt),
        .o_mcmd         (o_mcmd),
        .o_maddr        (o_maddr),
        .o_mburstlength (o_mburstlength),
        .i_scmdaccept   (i_scmdaccept),
        .i_sresp        (i_sresp),
        .i_sdata        (i_sdata),
        .o_rvalid       (o_rvalid),
        .o_rdata        (o_rdata),
        .o_busy         (o_busy),
        .o_err          (o_err),
        .i_err_clr      (i_err_clr)
    );

    always #5 vpp_clk = ~vpp_clk;

    typedef struct packed {
        logic [2:0]  rv;
        logic [31:0] d;
    } sb_entry_t;

    sb_entry_t sb [$];
    sb_entry_t mon_e;
    int        m_id   [$];
    int        m_blen [$];
    int        m_rem;
    bit        m_mid;
    bit        m_err;
    int        n_vec;
    int        n_bad;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int eff_blen(input logic [BLW-1:0] b);
        return (b == '0) ? 1 : int'(b);
    endfunction

    task automatic tick();
        @(posedge vpp_clk);
        #1;
    endtask

    // Predict one response beat against the model's outstanding-burst list.
    task automatic model_beat(input logic [1:0] resp, input logic [31:0] data);
        int rem;
        if (m_id.size() == 0) begin
            m_err = 1'b1;
        end else begin
            sb.push_back('{rv: 3'(3'b001 << m_id[0]), d: data});
            if (resp == RERR) m_err = 1'b1;
            rem = m_mid ? m_rem : m_blen[0];
            if (rem == 1) begin
                void'(m_id.pop_front());
                void'(m_blen.pop_front());
                m_mid = 1'b0;
            end else begin
                m_rem = rem - 1;
                m_mid = 1'b1;
            end
        end
    endtask

    task automatic beat(input logic [1:0] resp, input logic [31:0] data);
        i_sresp = resp;
        i_sdata = data;
        model_beat(resp, data);
        tick();
        i_sresp = RNULL;
    endtask

    task automatic err_clear();
        i_err_clr = 1'b1;
        tick();
        i_err_clr = 1'b0;
        m_err = 1'b0;
        chk("err_clr", 64'(o_err), 64'(m_err));
    endtask

    // Expects the FSM idle with exp_id as the arbitration winner of the current i_req.
    task automatic do_cmd(input int exp_id, input int waits, input bit beat_acc,
                          input logic [31:0] bdata);
        tick();
        chk("mcmd_rd", 64'(o_mcmd), 64'(3'b010));
        chk("maddr", 64'(o_maddr), 64'(addr_tab[exp_id]));
        chk("mburst", 64'(o_mburstlength), 64'(eff_blen(blen_tab[exp_id])));
        chk("gnt_wait", 64'(o_gnt), 64'd0);
        for (int w = 0; w < waits; w++) begin
            tick();
            chk("mcmd_hold", 64'(o_mcmd), 64'(3'b010));
            chk("maddr_hold", 64'(o_maddr), 64'(addr_tab[exp_id]));
        end
        i_scmdaccept = 1'b1;
        if (beat_acc) begin
            i_sresp = RDVA;
            i_sdata = bdata;
            model_beat(RDVA, bdata);
        end
        #1;
        chk("gnt", 64'(o_gnt), 64'(3'b001 << exp_id));
        tick();
        i_scmdaccept = 1'b0;
        i_sresp = RNULL;
        m_id.push_back(exp_id);
        m_blen.push_back(eff_blen(blen_tab[exp_id]));
        chk("mcmd_idle", 64'(o_mcmd), 64'd0);
    endtask

    task automatic do_reset();
        vpp_rst_b = 1'b0;
        i_req = 3'b000;
        i_scmdaccept = 1'b0;
        i_sresp = RNULL;
        i_err_clr = 1'b0;
        sb.delete();
        m_id.delete();
        m_blen.delete();
        m_mid = 1'b0;
        m_err = 1'b0;
        #1;
        chk("rst_gnt", 64'(o_gnt), 64'd0);
        chk("rst_mcmd", 64'(o_mcmd), 64'd0);
        chk("rst_maddr", 64'(o_maddr), 64'd0);
        chk("rst_mburst", 64'(o_mburstlength), 64'd0);
        chk("rst_rvalid", 64'(o_rvalid), 64'd0);
        chk("rst_rdata", 64'(o_rdata), 64'd0);
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_err", 64'(o_err), 64'd0);
        tick();
        tick();
        vpp_rst_b = 1'b1;
    endtask

    always @(negedge vpp_clk) begin
        if (vpp_rst_b && o_rvalid != 3'b000) begin
            if (sb.size() == 0) begin
                chk("rvalid_unexp", 64'(o_rvalid), 64'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("rvalid", 64'(o_rvalid), 64'(mon_e.rv));
                chk("rdata", 64'(o_rdata), 64'(mon_e.d));
            end
        end
    end

    initial begin
        n_vec = 0;
        n_bad = 0;
        addr_tab[0] = 32'h2000_0100;
        addr_tab[1] = 32'h3000_0200;
        addr_tab[2] = 32'h4000_0300;
        blen_tab[0] = 4'd4;
        blen_tab[1] = 4'd1;
        blen_tab[2] = 4'd1;
        #2;
        do_reset();

        // Single Y burst, accepted on the second command cycle.
        i_req = 3'b001;
        do_cmd(0, 1, 1'b0, 32'h0);
        i_req = 3'b000;
        chk("busy_out", 64'(o_busy), 64'd1);
        for (int i = 0; i < 4; i++) begin
            beat(RDVA, 32'hA000_0000 + 32'(i));
            chk("busy_single", 64'(o_busy), (i < 3) ? 64'd1 : 64'd0);
        end

        // Round robin from reset: Y,U,V then Y,U with V chosen from 101.
        do_reset();
        blen_tab[0] = 4'd1;
        i_req = 3'b111;
        do_cmd(0, 0, 1'b0, 32'h0);
        do_cmd(1, 0, 1'b0, 32'h0);
        do_cmd(2, 0, 1'b0, 32'h0);
        i_req = 3'b000;
        for (int i = 0; i < 3; i++) beat(RDVA, 32'hB000_0000 + 32'(i));
        chk("busy_rr", 64'(o_busy), 64'd0);
        i_req = 3'b111;
        do_cmd(0, 0, 1'b0, 32'h0);
        do_cmd(1, 0, 1'b0, 32'h0);
        i_req = 3'b101;
        do_cmd(2, 0, 1'b0, 32'h0);
        i_req = 3'b000;
        for (int i = 0; i < 3; i++) beat(RDVA, 32'hB100_0000 + 32'(i));

        // Outstanding limit: four accepts, then stall until a burst completes.
        do_reset();
        i_req = 3'b111;
        do_cmd(0, 0, 1'b0, 32'h0);
        do_cmd(1, 0, 1'b0, 32'h0);
        do_cmd(2, 0, 1'b0, 32'h0);
        do_cmd(0, 0, 1'b0, 32'h0);
        i_scmdaccept = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("full_idle", 64'(o_mcmd), 64'd0);
            chk("full_gnt", 64'(o_gnt), 64'd0);
        end
        i_scmdaccept = 1'b0;
        beat(RDVA, 32'hC000_0000);
        chk("full_pop_idle", 64'(o_mcmd), 64'd0);
        do_cmd(1, 0, 1'b0, 32'h0);
        i_req = 3'b000;
        for (int i = 0; i < 4; i++) beat(RDVA, 32'hC100_0000 + 32'(i));
        chk("busy_full", 64'(o_busy), 64'd0);

        // Interleaved Y(2) and V(3); Y's last beat coincides with V's accept.
        blen_tab[0] = 4'd2;
        blen_tab[2] = 4'd3;
        i_req = 3'b001;
        do_cmd(0, 0, 1'b0, 32'h0);
        i_req = 3'b000;
        beat(RDVA, 32'hD000_0001);
        i_req = 3'b100;
        do_cmd(2, 0, 1'b1, 32'hD000_0002);
        i_req = 3'b000;
        chk("busy_il", 64'(o_busy), 64'd1);
        for (int i = 0; i < 3; i++) begin
            beat(RDVA, 32'hD000_0003 + 32'(i));
            chk("busy_il_v", 64'(o_busy), (i < 2) ? 64'd1 : 64'd0);
        end

        // Error handling.
        do_reset();
        beat(RDVA, 32'hDEAD_0001);
        chk("err_unexp", 64'(o_err), 64'(m_err));
        err_clear();
        i_err_clr = 1'b1;
        beat(RDVA, 32'hDEAD_0002);
        i_err_clr = 1'b0;
        chk("err_set_wins", 64'(o_err), 64'(m_err));
        err_clear();
        i_req = 3'b001;
        do_cmd(0, 0, 1'b0, 32'h0);
        i_req = 3'b000;
        beat(RDVA, 32'hE000_0001);
        chk("err_dva", 64'(o_err), 64'(m_err));
        beat(RERR, 32'hE000_0002);
        chk("err_resp", 64'(o_err), 64'(m_err));
        err_clear();

        // Reset while in CMD with two bursts outstanding.
        blen_tab[1] = 4'd2;
        i_req = 3'b001;
        do_cmd(0, 0, 1'b0, 32'h0);
        i_req = 3'b010;
        do_cmd(1, 0, 1'b0, 32'h0);
        i_req = 3'b100;
        tick();
        chk("pre_rst_cmd", 64'(o_mcmd), 64'(3'b010));
        chk("pre_rst_busy", 64'(o_busy), 64'd1);
        do_reset();
        beat(RDVA, 32'hF000_0001);
        chk("err_late", 64'(o_err), 64'(m_err));
        err_clear();
        blen_tab[0] = 4'd0;
        i_req = 3'b111;
        do_cmd(0, 0, 1'b0, 32'h0);
        i_req = 3'b000;
        beat(RDVA, 32'hF000_0002);
        chk("busy_blen0", 64'(o_busy), 64'd0);

        tick();
        tick();
        chk("sb_drain", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
